seg7_scan_capture: RTL

- Receive side of the team's 7-segment display interface. It turns an active-low segment/anode scan bus back into hex digits.
- Passively samples a 4-digit time-multiplexed bus: segments a..g, decimal point, anode selects.
- Reconstructs each digit's 4-bit value, point and blank state, then publishes a complete 16-bit frame once all four digits have been captured.
- Used for display self-check and for loopback of the display path into the test harness.

---
 rtl/seg7_scan_capture.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_capture.sv
// Passive capture of a 4-digit active-low 7-segment scan bus into hex digits.
// Optional bus-stall detection is compiled in with `define SEG7_CAP_STALL_EN.
//
// state      | meaning
// S_IDLE     | no valid anode seen, waiting for exactly one selected digit
// S_SETTLE   | sample loaded, counting identical cycles toward STABLE_CYC
// S_CAPTURED | digit accepted into shadow, waiting for the bus to move on
module seg7_scan_capture #(
   parameter int STABLE_CYC = 4,
   parameter int STALL_CYC  = 65536
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg_n,
   input  logic        dp_n,
   input  logic [3:0]  an_n,
   output logic [15:0] value,
   output logic [3:0]  dots,
   output logic [3:0]  blank,
   output logic [3:0]  err,
   output logic        frame_valid,
   output logic        stall
);

   localparam int CNT_W = $clog2(STABLE_CYC) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_SETTLE   = 2'd1;
   localparam logic [1:0] S_CAPTURED = 2'd2;

   if (STABLE_CYC < 1) begin : g_bad_stable
      $error("seg7_scan_capture: STABLE_CYC must be at least 1");
   end
   if (STALL_CYC < 1) begin : g_bad_stall
      $error("seg7_scan_capture: STALL_CYC must be at least 1");
   end

   logic [6:0] seg_m_q, seg_s_q;
   logic       dp_m_q, dp_s_q;
   logic [3:0] an_m_q, an_s_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_m_q <= 7'h7F;
         seg_s_q <= 7'h7F;
         dp_m_q  <= 1'b1;
         dp_s_q  <= 1'b1;
         an_m_q  <= 4'hF;
         an_s_q  <= 4'hF;
      end else begin
         seg_m_q <= seg_n;
         seg_s_q <= seg_m_q;
         dp_m_q  <= dp_n;
         dp_s_q  <= dp_m_q;
         an_m_q  <= an_n;
         an_s_q  <= an_m_q;
      end
   end

   // {hit, nibble}; hit=0 means the pattern is not a hex glyph
   function automatic logic [4:0] decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h40:   r = 5'h10;
         7'h79:   r = 5'h11;
         7'h24:   r = 5'h12;
         7'h30:   r = 5'h13;
         7'h19:   r = 5'h14;
         7'h12:   r = 5'h15;
         7'h02:   r = 5'h16;
         7'h78:   r = 5'h17;
         7'h00:   r = 5'h18;
         7'h10:   r = 5'h19;
         7'h08:   r = 5'h1A;
         7'h03:   r = 5'h1B;
         7'h46:   r = 5'h1C;
         7'h21:   r = 5'h1D;
         7'h06:   r = 5'h1E;
         7'h0E:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   logic             an_ok;
   logic             stall_force;
   logic [1:0]       state_q, state_d;
   logic [3:0]       an_l_q, an_l_d;
   logic [6:0]       seg_l_q, seg_l_d;
   logic             dp_l_q, dp_l_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       mask_q, mask_d;
   logic [15:0]      sh_val_q, sh_val_d;
   logic [3:0]       sh_dots_q, sh_dots_d;
   logic [3:0]       sh_blank_q, sh_blank_d;
   logic [3:0]       sh_err_q, sh_err_d;
   logic [15:0]      value_q, value_d;
   logic [3:0]       dots_q, dots_d;
   logic [3:0]       blank_q, blank_d;
   logic [3:0]       err_q, err_d;
   logic             frame_valid_q, frame_valid_d;
   logic             load, same, is_blank;
   logic [4:0]       dec;

   always_comb begin
      an_ok = (an_s_q == 4'b1110) || (an_s_q == 4'b1101) ||
              (an_s_q == 4'b1011) || (an_s_q == 4'b0111);
   end

   always_comb begin
      state_d       = state_q;
      an_l_d        = an_l_q;
      seg_l_d       = seg_l_q;
      dp_l_d        = dp_l_q;
      cnt_d         = cnt_q;
      mask_d        = mask_q;
      sh_val_d      = sh_val_q;
      sh_dots_d     = sh_dots_q;
      sh_blank_d    = sh_blank_q;
      sh_err_d      = sh_err_q;
      value_d       = value_q;
      dots_d        = dots_q;
      blank_d       = blank_q;
      err_d         = err_q;
      frame_valid_d = 1'b0;
      load          = 1'b0;
      same          = (an_s_q == an_l_q) && (seg_s_q == seg_l_q) && (dp_s_q == dp_l_q);
      dec           = decode(seg_s_q);
      is_blank      = (seg_s_q == 7'h7F) && dp_s_q;

      // Publish reads the shadow before any capture this cycle lands in it
      if (mask_q == 4'hF) begin
         value_d       = sh_val_q;
         dots_d        = sh_dots_q;
         blank_d       = sh_blank_q;
         err_d         = sh_err_q;
         frame_valid_d = 1'b1;
         mask_d        = 4'h0;
      end

      if (stall_force) begin
         state_d = S_IDLE;
         mask_d  = 4'h0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (an_ok) load = 1'b1;
            end
            S_SETTLE: begin
               if (!an_ok) state_d = S_IDLE;
               else if (!same) load = 1'b1;
               else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            end
            S_CAPTURED: begin
               if (!an_ok) state_d = S_IDLE;
               else if (!same) load = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase

         if (load) begin
            an_l_d  = an_s_q;
            seg_l_d = seg_s_q;
            dp_l_d  = dp_s_q;
            cnt_d   = CNT_ONE;
            state_d = S_SETTLE;
         end

         if (state_d == S_SETTLE && cnt_d == CNT_MAX) begin
            state_d = S_CAPTURED;
            for (int i = 0; i < 4; i++) begin
               if (!an_s_q[i]) begin
                  sh_val_d[4*i +: 4] = dec[3:0];
                  sh_dots_d[i]       = ~dp_s_q;
                  sh_blank_d[i]      = is_blank;
                  sh_err_d[i]        = ~dec[4] & ~is_blank;
                  mask_d[i]          = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         an_l_q        <= 4'hF;
         seg_l_q       <= 7'h7F;
         dp_l_q        <= 1'b1;
         cnt_q         <= '0;
         mask_q        <= 4'h0;
         sh_val_q      <= 16'h0;
         sh_dots_q     <= 4'h0;
         sh_blank_q    <= 4'h0;
         sh_err_q      <= 4'h0;
         value_q       <= 16'h0;
         dots_q        <= 4'h0;
         blank_q       <= 4'h0;
         err_q         <= 4'h0;
         frame_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         an_l_q        <= an_l_d;
         seg_l_q       <= seg_l_d;
         dp_l_q        <= dp_l_d;
         cnt_q         <= cnt_d;
         mask_q        <= mask_d;
         sh_val_q      <= sh_val_d;
         sh_dots_q     <= sh_dots_d;
         sh_blank_q    <= sh_blank_d;
         sh_err_q      <= sh_err_d;
         value_q       <= value_d;
         dots_q        <= dots_d;
         blank_q       <= blank_d;
         err_q         <= err_d;
         frame_valid_q <= frame_valid_d;
      end
   end

`ifdef SEG7_CAP_STALL_EN
   localparam int STL_W = $clog2(STALL_CYC + 1);
   localparam logic [STL_W-1:0] STL_MAX = STL_W'(STALL_CYC);

   logic [STL_W-1:0] stl_cnt_q, stl_cnt_d;
   logic [3:0]       an_prev_q, an_prev_d;
   logic             stall_q, stall_d;
   logic             an_change;

   // an_prev tracks the last valid anode, so a glitch through an invalid code
   // back to the same digit is not mistaken for scanning activity
   always_comb begin
      an_change   = an_ok && (an_s_q != an_prev_q);
      an_prev_d   = an_ok ? an_s_q : an_prev_q;
      stl_cnt_d   = stl_cnt_q;
      stall_d     = stall_q;
      stall_force = 1'b0;
      if (an_change) begin
         stl_cnt_d = '0;
         stall_d   = 1'b0;
      end else if (stl_cnt_q == STL_MAX) begin
         stall_d     = 1'b1;
         stall_force = 1'b1;
      end else begin
         stl_cnt_d = stl_cnt_q + STL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stl_cnt_q <= '0;
         an_prev_q <= 4'hF;
         stall_q   <= 1'b0;
      end else begin
         stl_cnt_q <= stl_cnt_d;
         an_prev_q <= an_prev_d;
         stall_q   <= stall_d;
      end
   end

   assign stall = stall_q;
`else
   assign stall_force = 1'b0;
   assign stall       = 1'b0;
`endif

   assign value       = value_q;
   assign dots        = dots_q;
   assign blank       = blank_q;
   assign err         = err_q;
   assign frame_valid = frame_valid_q;

endmodule
